debouncer_multi: RTL
====================

// Module: debouncer_multi
// PURPOSE
//   Multi-channel debouncer for push-buttons, switches and other bouncy level inputs.
//   Each channel optionally synchronises its raw input, then filters it through a
//   per-channel stability counter, and reports clean levels plus one-cycle edge pulses.
//   Sits between the pad inputs and control logic; replaces N single-channel debouncers.
// PARAMETERS
//   p_CHANNELS     8   number of independent input channels (>=1)
//   p_CNT_WIDTH    4   counter width; stability threshold T = 2**p_CNT_WIDTH cycles
//   p_INIT_VALUE   0   p_CHANNELS-bit reset level of o_output and the synchroniser flops, bit i = channel i
//   p_SYNC_STAGES  2   input synchroniser depth, 0..3; 0 = i_input used directly
// PORTS
//   i_clk         in   1            clock, all state on posedge
//   i_rst_n       in   1            asynchronous active-low reset
//   i_en          in   1            sample enable; 0 freezes filter state
//   i_input       in   p_CHANNELS   raw bouncy inputs
//   o_output      out  p_CHANNELS   debounced levels (registered)
//   o_rise        out  p_CHANNELS   1-cycle pulse: channel went 0->1
//   o_fall        out  p_CHANNELS   1-cycle pulse: channel went 1->0
//   o_change_any  out  1            1-cycle pulse: any bit of o_rise|o_fall set
// BEHAVIOUR
//   Reset (i_rst_n=0, takes effect immediately, no clock needed):
//     o_output=p_INIT_VALUE, sync flops=p_INIT_VALUE, counters=0, o_rise=o_fall=0, o_change_any=0.
//     No edge pulse is generated on reset release, even if i_input != p_INIT_VALUE.
//   Synchroniser: s = i_input delayed p_SYNC_STAGES flops; it runs every clock regardless of i_en.
//   Per channel i, on each posedge with i_en=1:
//     s[i]==o_output[i]            -> cnt[i]<=0 (any agreeing cycle fully restarts the count, no decrement)
//     s[i]!=o_output[i], cnt<T-1   -> cnt[i]<=cnt[i]+1
//     s[i]!=o_output[i], cnt==T-1  -> o_output[i]<=s[i], cnt[i]<=0, rise/fall pulse
//   => o_output flips on the T-th consecutive enabled cycle of disagreement; a run of T-1
//      cycles never changes it. Pin-to-output latency = p_SYNC_STAGES + T cycles.
//   Counter never wraps: the maximum value is T-1, and the flip resets it to 0.
//   Pulses: o_rise[i]/o_fall[i] are registered and rise on the same edge that o_output[i]
//     changes; they are high for exactly one cycle. o_change_any = |(next o_rise | next o_fall),
//     registered, so it is aligned with the pulses.
//   i_en=0: counters, o_output hold; pulses forced 0 that cycle; cycles with i_en=0 neither count
//     nor break a run (disagreement across an i_en gap accumulates).
//   Channels are fully independent; simultaneous flips on several channels give one
//     o_change_any cycle.
//   Reset mid-count: counters cleared; filtering restarts from 0 after release.
// TESTING  (p_CHANNELS=4, p_CNT_WIDTH=2 (T=4), p_SYNC_STAGES=2, p_INIT_VALUE=4'b1000)
//   1. Toggle i_input[0] every clock for 12 cycles -> o_output stays 4'b1000, no pulses.
//   2. i_input[1]=1 for exactly 3 cycles, then 0 -> o_output[1] stays 0, no pulses.
//   3. i_input[2]=1 held -> o_output[2]=1 exactly 6 edges later; o_rise[2] and o_change_any
//      high 1 cycle. Then i_input[2]=0 held -> o_fall[2] and o_output[2]=0 6 edges later.
//   4. Same edge: i_input[0]=1, i_input[3]=0, both held -> o_rise[0] and o_fall[3] pulse
//      in the same cycle; o_output=4'b0001; o_change_any high exactly 1 cycle.
//   5. i_en=0, i_input[1]=1 held 10 cycles -> no change; i_en=1 -> o_output[1]=1 after
//      4 enabled edges.
//   6. i_input[2]=1, drop i_rst_n after 3 cycles -> o_output=4'b1000 at once, async; release
//      -> no pulse on release; o_output[2]=1 after a full T run from the release.

Source files
------------

// File: rtl/debouncer_multi.sv
// Multi-channel level debouncer: optional input synchroniser, per-channel stability
// counter, registered clean levels with aligned one-cycle rise/fall/any-change pulses.
module debouncer_multi #(
  parameter int                      p_CHANNELS    = 8,
  parameter int                      p_CNT_WIDTH   = 4,
  parameter logic [p_CHANNELS-1:0]   p_INIT_VALUE  = '0,
  parameter int                      p_SYNC_STAGES = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  input  logic [p_CHANNELS-1:0] i_input,
  output logic [p_CHANNELS-1:0] o_output,
  output logic [p_CHANNELS-1:0] o_rise,
  output logic [p_CHANNELS-1:0] o_fall,
  output logic                  o_change_any
);

  localparam logic [p_CNT_WIDTH-1:0] c_TERM = '1;
  localparam logic [p_CNT_WIDTH-1:0] c_ONE  = p_CNT_WIDTH'(1);

  logic [p_CHANNELS-1:0] s_w;

  // The synchroniser runs every clock so i_en only gates filtering, not sampling.
  generate
    if (p_SYNC_STAGES == 0) begin : g_nosync
      assign s_w = i_input;
    end else begin : g_sync
      logic [p_CHANNELS-1:0] sync_q [p_SYNC_STAGES];

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          for (int k = 0; k < p_SYNC_STAGES; k++) sync_q[k] <= p_INIT_VALUE;
        end else begin
          sync_q[0] <= i_input;
          for (int k = 1; k < p_SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
      end

      assign s_w = sync_q[p_SYNC_STAGES-1];
    end
  endgenerate

  logic [p_CHANNELS-1:0][p_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [p_CHANNELS-1:0]                  out_q, out_d;
  logic [p_CHANNELS-1:0]                  rise_q, rise_d;
  logic [p_CHANNELS-1:0]                  fall_q, fall_d;
  logic                                   chg_q, chg_d;

  always_comb begin
    cnt_d  = cnt_q;
    out_d  = out_q;
    rise_d = '0;
    fall_d = '0;
    if (i_en) begin
      for (int i = 0; i < p_CHANNELS; i++) begin
        if (s_w[i] == out_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == c_TERM) begin
          // T-th consecutive disagreeing enabled cycle: accept the new level
          out_d[i]  = s_w[i];
          cnt_d[i]  = '0;
          rise_d[i] = s_w[i];
          fall_d[i] = ~s_w[i];
        end else begin
          cnt_d[i] = cnt_q[i] + c_ONE;
        end
      end
    end
    chg_d = |(rise_d | fall_d);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q  <= '0;
      out_q  <= p_INIT_VALUE;
      rise_q <= '0;
      fall_q <= '0;
      chg_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      chg_q  <= chg_d;
    end
  end

  assign o_output     = out_q;
  assign o_rise       = rise_q;
  assign o_fall       = fall_q;
  assign o_change_any = chg_q;

endmodule
